bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
Sequential, parametrised successor to the two-digit combinational BCD-to-binary converter. Converts an NDIGITS-digit packed BCD word to unsigned binary with one multiply-by-10-and-add step per clock, MSD first. Uses a start/busy/done handshake and flags any digit greater than 9. Sits between BCD keypad/display logic and binary datapaths.

Parameters:
NDIGITS, 4, number of BCD digits in the input (1..8).
OUT_W, 14, binary result width. Must satisfy 2^OUT_W > 10^NDIGITS - 1; the default covers 9999.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request conversion; sampled only when the block is idle or in DONE.
bcd_in  input  4*NDIGITS  packed BCD. Bits [4*NDIGITS-1 -: 4] are the MSD; bits [3:0] are the LSD.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when the result is valid.
bin_out  output  OUT_W  binary result; held until the next accepted start.
err  output  1  invalid-digit flag for the last conversion; held with bin_out.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset, asserted at any time, including mid-conversion:
  - State goes to IDLE.
  - busy=0, done=0, err=0, bin_out=0.
  - Accumulator, digit counter and captured input are all cleared.
  - After rst_n deasserts, the block accepts start on the next edge.
- States:
  - IDLE: busy=0, done=0. On start=1, capture bcd_in into a shift register, clear acc, cnt and the err accumulator, then go to CONV.
  - CONV: busy=1. Each cycle:
    - acc <= acc*10 + d, where d is the current MSD of the shift register.
    - Shift the register left by 4.
    - cnt <= cnt+1.
    - If d > 9, set the internal err accumulator (sticky for this conversion).
    - When cnt == NDIGITS-1, go to DONE.
  - DONE (one cycle): done=1, busy=0.
    - bin_out = 0 and err=1 if any digit was invalid; otherwise bin_out = final acc and err=0.
    - bin_out and err are registered on entry to DONE and held until the next accepted start.
    - If start=1 in DONE, capture a new operand and go to CONV (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+NDIGITS. Converter throughput is NDIGITS+1 cycles per conversion.
- start asserted while busy=1 is ignored; there is no queueing. Changes on bcd_in after capture have no effect.
- Arithmetic:
  - acc*10 is formed as (acc<<3)+(acc<<1), computed in OUT_W+4 bits and truncated to OUT_W.
  - With valid digits and a legal OUT_W, no truncation occurs.
  - Invalid digits still enter the arithmetic, but the result is discarded (bin_out=0).
- bin_out is stable in IDLE and during CONV: it keeps the previous result until DONE.
- NDIGITS=1 is legal: one CONV cycle, then DONE.

Test Plan:
- Reset then start with bcd_in=16'h0000 -> done after 5 cycles; bin_out=0, err=0. Repeat with 16'h9999 -> bin_out=9999 (14'h270F), err=0.
- Sweep D1,D0 over 0..9 with the upper digits 0 (bcd_in=16'h00XY) -> bin_out=10*X+Y in all 100 cases, matching the legacy two-digit converter.
- bcd_in=16'h12A4 -> done with err=1, bin_out=0. Next start with 16'h1234 -> err=0, bin_out=1234.
- start with 16'h0042, then pulse start with 16'h0777 two cycles later while busy=1 -> single done, bin_out=42. Also hold start=1 through DONE with 16'h0100 captured there -> second done exactly 5 cycles later, bin_out=100.
- Drop rst_n for 1 cycle in the third CONV cycle of 16'h5678 -> all outputs 0 immediately (asynchronous), no done pulse. A fresh start with 16'h0005 -> bin_out=5.
- Parameter sweep NDIGITS=1/OUT_W=4 and NDIGITS=6/OUT_W=20:
  - 4'h9 -> 9 after 2 cycles.
  - 24'h999999 -> 999999 after 7 cycles.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter.
// Processes one digit per clock, most significant digit first, using acc = acc*10 + digit.
module bcd_to_bin_seq #(
    parameter int NDIGITS = 4,
    parameter int OUT_W   = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd_in,
    output logic                   busy,
    output logic                   done,
    output logic [OUT_W-1:0]       bin_out,
    output logic                   err
);

    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [4*NDIGITS-1:0]   r_sr;
    logic [OUT_W-1:0]       r_acc;
    logic [CW-1:0]          r_cnt;
    logic                   r_err_acc;

    logic [3:0]             w_digit;
    logic [OUT_W-1:0]       w_acc_next;
    logic                   w_err_next;
    logic                   w_last;

    assign w_digit    = r_sr[4*NDIGITS-1 -: 4];
    // acc*10 as (acc<<3)+(acc<<1) with 4 bits of headroom, then truncated to OUT_W.
    assign w_acc_next = OUT_W'(({4'b0, r_acc} << 3) + ({4'b0, r_acc} << 1)
                               + {{OUT_W{1'b0}}, w_digit});
    assign w_err_next = r_err_acc | (w_digit > 4'd9);
    assign w_last     = (r_cnt == CW'(NDIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bin_out   <= '0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sr      <= bcd_in;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_err_acc <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_acc     <= w_acc_next;
                    r_sr      <= r_sr << 4;
                    r_cnt     <= r_cnt + 1'b1;
                    r_err_acc <= w_err_next;
                    if (w_last) begin
                        // Invalid digits still flow through the arithmetic; the sum is discarded here.
                        bin_out <= w_err_next ? '0 : w_acc_next;
                        err     <= w_err_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sr      <= bcd_in;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_err_acc <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_CONV;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: default, 1-digit and 6-digit instances.
// Stimulus pushes expectations; per-instance monitors pop and check them on each done pulse.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        start,  busy,  done,  err;
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        start1, busy1, done1, err1;
    logic [3:0]  bcd1;
    logic [3:0]  bin1;
    logic        start6, busy6, done6, err6;
    logic [23:0] bcd6;
    logic [19:0] bin6;

    bcd_to_bin_seq #(.NDIGITS(4), .OUT_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd),
        .busy(busy), .done(done), .bin_out(bin), .err(err));
    bcd_to_bin_seq #(.NDIGITS(1), .OUT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bcd_in(bcd1),
        .busy(busy1), .done(done1), .bin_out(bin1), .err(err1));
    bcd_to_bin_seq #(.NDIGITS(6), .OUT_W(20)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .bcd_in(bcd6),
        .busy(busy6), .done(done6), .bin_out(bin6), .err(err6));

    typedef struct {
        int bin;
        bit err;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q6[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Monitors: one per instance, sampling on the falling edge.
    exp_t m0, m1, m6;
    always @(negedge clk) begin
        if (done) begin
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL main_unexpected_done: got bin=%0d err=%0d, required no done", bin, err);
            end else begin
                m0 = q0.pop_front();
                chk("main_bin", int'(bin), m0.bin);
                chk("main_err", int'(err), int'(m0.err));
                chk("main_done_cycle", cyc, m0.cyc);
                chk("main_busy_at_done", int'(busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL n1_unexpected_done: got bin=%0d, required no done", bin1);
            end else begin
                m1 = q1.pop_front();
                chk("n1_bin", int'(bin1), m1.bin);
                chk("n1_err", int'(err1), int'(m1.err));
                chk("n1_done_cycle", cyc, m1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (done6) begin
            if (q6.size() == 0) begin
                n_chk++;
                $display("FAIL n6_unexpected_done: got bin=%0d, required no done", bin6);
            end else begin
                m6 = q6.pop_front();
                chk("n6_bin", int'(bin6), m6.bin);
                chk("n6_err", int'(err6), int'(m6.err));
                chk("n6_done_cycle", cyc, m6.cyc);
            end
        end
    end

    // Issue tasks are called on a falling edge; start is sampled at edge cyc+1.
    task automatic go0(input logic [15:0] v, input int eb, input bit ee);
        exp_t e;
        e.bin = eb; e.err = ee; e.cyc = cyc + 1 + 4;
        q0.push_back(e);
        start = 1'b1; bcd = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go1(input logic [3:0] v, input int eb, input bit ee);
        exp_t e;
        e.bin = eb; e.err = ee; e.cyc = cyc + 1 + 1;
        q1.push_back(e);
        start1 = 1'b1; bcd1 = v;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic go6(input logic [23:0] v, input int eb, input bit ee);
        exp_t e;
        e.bin = eb; e.err = ee; e.cyc = cyc + 1 + 6;
        q6.push_back(e);
        start6 = 1'b1; bcd6 = v;
        @(negedge clk);
        start6 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() + q1.size() + q6.size()) != 0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (t >= 80) begin
            chk("drain_timeout_pending", q0.size() + q1.size() + q6.size(), 0);
            q0.delete(); q1.delete(); q6.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int c0;
        logic [15:0] v;
        start = 1'b0; start1 = 1'b0; start6 = 1'b0;
        bcd = '0; bcd1 = '0; bcd6 = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bin", int'(bin), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_n6_bin", int'(bin6), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        go0(16'h0000, 0, 1'b0);
        chk("busy_after_start", int'(busy), 1);
        drain();
        go0(16'h9999, 9999, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_idle_bin", int'(bin), 9999);
        chk("idle_busy", int'(busy), 0);

        // Two-digit sweep: matches the legacy combinational converter.
        for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
                v = {8'h00, 4'(x), 4'(y)};
                go0(v, 10 * x + y, 1'b0);
                drain();
            end
        end

        go0(16'h12A4, 0, 1'b1);
        @(negedge clk);
        chk("hold_conv_bin", int'(bin), 99);
        drain();
        go0(16'h1234, 1234, 1'b0);
        drain();

        // Start while busy is ignored; start held through DONE restarts back-to-back.
        c0 = cyc;
        go0(16'h0042, 42, 1'b0);
        @(negedge clk);
        start = 1'b1; bcd = 16'h0777;
        @(negedge clk);
        bcd = 16'h0100;
        begin
            exp_t e;
            e.bin = 100; e.err = 1'b0; e.cyc = c0 + 10;
            q0.push_back(e);
        end
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        drain();

        // Asynchronous reset in the middle of a conversion.
        start = 1'b1; bcd = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_bin", int'(bin), 0);
        chk("midrst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_idle_busy", int'(busy), 0);
        go0(16'h0005, 5, 1'b0);
        drain();

        // Other parameterisations.
        go1(4'h9, 9, 1'b0);
        go6(24'h999999, 999999, 1'b0);
        drain();
        go1(4'hA, 0, 1'b1);
        go6(24'h123456, 123456, 1'b0);
        drain();
        go6(24'h9F0000, 0, 1'b1);
        go1(4'h0, 0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
        $fatal(1);
    end

endmodule
